// File: rtl/mb_radix8_pipe.sv
// rtl/mb_radix8_pipe.sv - 3-stage radix-8 Booth multiplier with valid/ready handshake
// Define MB_RADIX8_PIPE_SIGNED_EN to honour in_signed; otherwise the block is unsigned only.
module mb_radix8_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product
);

  localparam int GROUPS = WIDTH / 3 + 1;
  localparam int PW     = 2 * WIDTH;
  localparam int M      = WIDTH + 3;
  localparam int XE     = 3 * GROUPS + 1;

  // Each row carries its top bit inverted (adds 2^(M-1) per row); this constant takes it back out.
  function automatic logic [PW-1:0] corr_vec();
    logic [PW-1:0] acc;
    acc = '0;
    for (int j = 0; j < GROUPS; j++) begin
      if (M - 1 + 3 * j < PW) acc = acc - (PW'(1) << (M - 1 + 3 * j));
    end
    return acc;
  endfunction

  localparam logic [PW-1:0] CORR = corr_vec();

  logic               adv;
  logic               v1, v2, v3;
  logic [WIDTH-1:0]   x1, y1;
  logic [WIDTH+1:0]   y3_1;
  logic               m1;
  logic               in_sgn;
  logic [WIDTH+1:0]   ye_in, y3_in;
  logic [PW-1:0]      s2, c2, s_nxt, c_nxt;
  logic [PW-1:0]      prod;
  logic               xs, ys;
  logic [XE-1:0]      xe;
  logic [M-1:0]       ym, y2m, y3m, y4m;

  assign adv         = ~v3 | out_ready;
  assign in_ready    = adv;
  assign out_valid   = v3;
  assign out_product = prod;

`ifdef MB_RADIX8_PIPE_SIGNED_EN
  assign in_sgn = in_signed;

  always_ff @(posedge clk) begin
    if (adv && in_valid) m1 <= in_signed;
  end
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign in_sgn        = 1'b0;
  assign m1            = 1'b0;
`endif

  assign ye_in = {{2{in_sgn & in_y[WIDTH-1]}}, in_y};
  assign y3_in = ye_in + {ye_in[WIDTH:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      x1   <= in_x;
      y1   <= in_y;
      y3_1 <= y3_in;
    end
    if (adv && v1) begin
      s2 <= s_nxt;
      c2 <= c_nxt;
    end
  end

  assign xs  = m1 & x1[WIDTH-1];
  assign ys  = m1 & y1[WIDTH-1];
  assign xe  = {{(XE-1-WIDTH){xs}}, x1, 1'b0};
  assign ym  = {{3{ys}}, y1};
  assign y2m = {ym[M-2:0], 1'b0};
  assign y4m = {ym[M-3:0], 2'b00};
  assign y3m = {m1 & y3_1[WIDTH+1], y3_1};

  always_comb begin : booth_csa
    logic [3:0]    w;
    logic [3:0]    sel;
    logic          neg;
    logic [M-1:0]  pp;
    logic [PW-1:0] row, t, nv;
    s_nxt = CORR;
    c_nxt = '0;
    nv    = '0;
    for (int j = 0; j < GROUPS; j++) begin
      w   = xe[3*j +: 4];
      sel = 4'b0000;
      neg = 1'b0;
      case (w)
        4'b0001, 4'b0010: sel = 4'b0001;
        4'b0011, 4'b0100: sel = 4'b0010;
        4'b0101, 4'b0110: sel = 4'b0100;
        4'b0111:          sel = 4'b1000;
        4'b1000:          begin sel = 4'b1000; neg = 1'b1; end
        4'b1001, 4'b1010: begin sel = 4'b0100; neg = 1'b1; end
        4'b1011, 4'b1100: begin sel = 4'b0010; neg = 1'b1; end
        4'b1101, 4'b1110: begin sel = 4'b0001; neg = 1'b1; end
        default:          sel = 4'b0000;
      endcase
      pp = ({M{sel[0]}} & ym) | ({M{sel[1]}} & y2m) |
           ({M{sel[2]}} & y3m) | ({M{sel[3]}} & y4m);
      if (neg) pp = ~pp;
      pp[M-1] = ~pp[M-1];
      row = PW'({{PW{1'b0}}, pp} << (3 * j));
      nv[3*j] = neg;
      t     = s_nxt ^ c_nxt ^ row;
      c_nxt = ((s_nxt & c_nxt) | (s_nxt & row) | (c_nxt & row)) << 1;
      s_nxt = t;
    end
    // Fold the +1 two's-complement corrections of the negated rows in last.
    t     = s_nxt ^ c_nxt ^ nv;
    c_nxt = ((s_nxt & c_nxt) | (s_nxt & nv) | (c_nxt & nv)) << 1;
    s_nxt = t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod <= '0;
    end else if (adv && v2) begin
      prod <= s2 + c2;
    end
  end

endmodule

// File: doc/mb_radix8_pipe.md
MB_RADIX8_PIPE -- requirements
Module: mb_radix8_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter GROUPS, derived (not overridable), equal to floor(WIDTH/3)+1 radix-8 Booth groups.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 in_x  input  WIDTH  multiplier, Booth-recoded.
REQ-008 in_y  input  WIDTH  multiplicand.
REQ-009 in_signed  input  1  1 = two's-complement operands; 0 = unsigned.
REQ-010 out_valid  output  1  out_product holds a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_product  output  2*WIDTH  full-width product.

Function
REQ-013 Transfer occurs on an edge where valid and ready are both 1, on either port.
REQ-014 Three pipeline stages: S1 registers x, y, mode and the hard multiple 3Y (WIDTH+2 bits); S2 performs Booth encoding, partial-product selection and carry-save reduction to two 2*WIDTH vectors; S3 performs the final carry-propagate add into the out_product register.
REQ-015 Each stage has a valid bit; stage advance enable adv = ~out_valid | out_ready, common to all stages.
REQ-016 in_ready shall equal adv, combinationally; S1 captures on in_valid & adv, else loads a bubble when adv=1.
REQ-017 Latency with out_ready held 1 is exactly 3 cycles from input transfer to out_valid=1; throughput is one result per cycle.
REQ-018 When adv=0, every stage register, including out_product, holds its value.
REQ-019 The Booth encoder shall map each 4-bit window {x[3j+2:3j], x[3j-1]} (x[-1]=0) to a digit in -4..+4 using one-hot single/double/triple/quad selects plus neg.
REQ-020 Negative partial products use bit inversion plus a +1 correction bit; sign extension uses a constant correction vector; no variable-length sign extension.
REQ-021 Unsigned mode: bits above WIDTH-1 of x and y are zero-extended into the top group; out_product = x*y exactly.
REQ-022 Signed mode: bits above WIDTH-1 are sign-extended; out_product = two's-complement x*y exactly, including both operands = -2^(WIDTH-1).
REQ-023 in_signed is sampled with the operands and travels with them; mixed-mode back-to-back operands produce correct results.
REQ-024 Simultaneous out_ready=1 with out_valid=1 and a new input transfer: the output is replaced in the same edge with no bubble.

Reset
REQ-025 On rst=1, all stage valid bits clear immediately; out_valid=0, out_product=0, and in_ready=1 once rst deasserts.
REQ-026 Reset mid-operation discards all in-flight operands; no result from before reset ever appears.
REQ-027 Datapath registers other than out_product need not be reset.

Configuration
REQ-028 Macro MB_RADIX8_PIPE_SIGNED_EN: when defined, in_signed selects the mode per REQ-021/022.
REQ-029 When undefined, in_signed is ignored, the block is unsigned only, and sign-extension logic is not synthesised; the port remains present.

Verification
REQ-030 WIDTH=8, unsigned, x=0xFF, y=0xFF, out_ready=1 -> out_valid on the 3rd edge after transfer, out_product=0xFE01.
REQ-031 WIDTH=8, macro defined, signed: x=0x80,y=0x80 -> 0x4000; x=0xFF,y=0x01 -> 0xFFFF; with macro undefined, x=0xFF,y=0x01 -> 0x00FF.
REQ-032 Streaming: 100 random pairs on consecutive cycles with out_ready=1 -> 100 consecutive correct products, in order, in_ready always 1.
REQ-033 Backpressure: out_ready=0 while 4 pairs are offered -> 3 accepted, then in_ready=0; out_product stable; on out_ready=1, results drain in order with none lost or duplicated.
REQ-034 rst pulsed with 3 operands in flight -> out_valid=0 during and after reset; the next input yields only its own product after 3 cycles.
REQ-035 Sweep WIDTH in {4,8,12,16,32} with exhaustive (WIDTH<=8) or 10^5 random operands in both modes -> every product matches the reference model.
